// File: rtl/hc_request_arbiter.sv
// Round-robin arbiter sharing the HardCloud requestor command port among N_REQ
// buffer-side requesters, with a one-entry output register and a credit limit.

module hc_req_lane #(
    parameter int OFFSET_W = 42
) (
    input  logic                valid_i,
    input  logic [2:0]          cmd_i,
    input  logic [OFFSET_W-1:0] offset_i,
    output logic                elig_o,
    output logic [2:0]          cmd_o,
    output logic [OFFSET_W-1:0] offset_o
);
    // A valid request carrying IDLE is not a real command and never wins.
    assign elig_o   = valid_i && (cmd_i != 3'h0);
    assign cmd_o    = cmd_i;
    assign offset_o = offset_i;
endmodule

module hc_request_arbiter #(
    parameter int N_REQ            = 2,
    parameter int OFFSET_W         = 42,
    parameter int ID_W             = $clog2(N_REQ) + 1,
    parameter int MAX_OUTSTANDING  = 8,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1,
    localparam int PTR_W           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [3*N_REQ-1:0]        req_cmd,
    input  logic [OFFSET_W*N_REQ-1:0] req_offset,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      out_valid,
    output logic [2:0]                out_cmd,
    output logic [ID_W-1:0]           out_id,
    output logic [OFFSET_W-1:0]       out_offset,
    input  logic                      out_ready,
    input  logic                      rsp_done,
    output logic [CNT_W-1:0]          outstanding,
    output logic                      busy,
    output logic                      err_underflow
);
    localparam logic [2:0] E_REQUEST_IDLE = 3'h0;

    logic [N_REQ-1:0]                elig;
    logic [N_REQ-1:0][2:0]           lane_cmd;
    logic [N_REQ-1:0][OFFSET_W-1:0]  lane_off;

    logic                out_valid_q;
    logic [2:0]          out_cmd_q;
    logic [ID_W-1:0]     out_id_q;
    logic [OFFSET_W-1:0] out_offset_q;
    logic [CNT_W-1:0]    outstanding_q;
    logic                err_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PTR_W-1:0]    rr_ptr_d;

    logic             found;
    logic [PTR_W-1:0] gnt_idx;
    logic             slot_free;
    logic             credit_ok;
    logic             grant;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        hc_req_lane #(.OFFSET_W(OFFSET_W)) u_lane (
            .valid_i  (req_valid[i]),
            .cmd_i    (req_cmd[3*i +: 3]),
            .offset_i (req_offset[OFFSET_W*i +: OFFSET_W]),
            .elig_o   (elig[i]),
            .cmd_o    (lane_cmd[i]),
            .offset_o (lane_off[i])
        );
    end

    // First eligible requester scanning from rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && elig[idx]) begin
                found   = 1'b1;
                gnt_idx = PTR_W'(idx);
            end
        end
    end

    assign slot_free = !out_valid_q || out_ready;
    assign credit_ok = outstanding_q < CNT_W'(MAX_OUTSTANDING);
    assign grant     = found && slot_free && credit_ok && !reset;
    assign rr_ptr_d  = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++)
            req_ready[i] = grant && (gnt_idx == PTR_W'(i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_cmd_q     <= E_REQUEST_IDLE;
            out_id_q      <= '0;
            out_offset_q  <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            rr_ptr_q      <= '0;
        end else begin
            if (grant) begin
                out_valid_q  <= 1'b1;
                out_cmd_q    <= lane_cmd[gnt_idx];
                out_offset_q <= lane_off[gnt_idx];
                out_id_q     <= ID_W'(gnt_idx);
                rr_ptr_q     <= rr_ptr_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            // Credit is consumed at grant time, not when the requestor accepts.
            if (grant && !rsp_done) begin
                outstanding_q <= outstanding_q + CNT_W'(1);
            end else if (!grant && rsp_done) begin
                if (outstanding_q == '0) err_q <= 1'b1;
                else                     outstanding_q <= outstanding_q - CNT_W'(1);
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_cmd       = out_cmd_q;
    assign out_id        = out_id_q;
    assign out_offset    = out_offset_q;
    assign outstanding   = outstanding_q;
    assign err_underflow = err_q;
    assign busy          = out_valid_q || (outstanding_q != '0);
endmodule
